// File: rtl/comparator_bist.sv
// comparator_bist: self-test sequencer that sweeps operand pairs into a magnitude comparator and checks its one-hot flags
module comparator_bist #(
    parameter int WIDTH       = 8,
    parameter int SWEEP       = 16,
    parameter int SETTLE      = 2,
    parameter int STOP_ON_ERR = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    input  logic             eq_i,
    input  logic             lw_i,
    input  logic             gr_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b,
    output logic [2:0]       err_flags,
    output logic [15:0]      err_count
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WIDTH-1:0] LAST = WIDTH'(SWEEP - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SETTLE, S_CHECK, S_FINISH} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, err_a_q, err_a_d, err_b_q, err_b_d;
    logic [2:0]       err_flags_q, err_flags_d;
    logic [15:0]      err_count_q, err_count_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
    logic [2:0]       got, expect_flags;
    logic             mismatch;

    assign got          = {eq_i, lw_i, gr_i};
    assign expect_flags = {a_q == b_q, a_q < b_q, a_q > b_q};
    assign mismatch     = got != expect_flags;

    // Next-state logic; flags are only consulted in CHECK so junk elsewhere is harmless
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        err_a_d     = err_a_q;
        err_b_d     = err_b_q;
        err_flags_d = err_flags_q;
        err_count_d = err_count_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_d      = fail_q;
        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    state_d     = S_SETUP;
                    a_d         = '0;
                    b_d         = '0;
                    err_a_d     = '0;
                    err_b_d     = '0;
                    err_flags_d = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            S_SETUP: begin
                cnt_d   = CW'(SETTLE - 1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = (cnt_q == '0) ? S_CHECK : S_SETTLE;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
                    fail_d      = 1'b1;
                    if (!fail_q) begin
                        err_a_d     = a_q;
                        err_b_d     = b_q;
                        err_flags_d = got;
                    end
                end
                if ((mismatch && STOP_ON_ERR != 0) || (a_q == LAST && b_q == LAST)) begin
                    state_d = S_FINISH;
                end else if (b_q == LAST) begin
                    b_d     = '0;
                    a_d     = a_q + WIDTH'(1);
                    state_d = S_SETUP;
                end else begin
                    b_d     = b_q + WIDTH'(1);
                    state_d = S_SETUP;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = !fail_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any sweep in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            err_a_q     <= '0;
            err_b_q     <= '0;
            err_flags_q <= '0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            err_a_q     <= err_a_d;
            err_b_q     <= err_b_d;
            err_flags_q <= err_flags_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign err_a     = err_a_q;
    assign err_b     = err_b_q;
    assign err_flags = err_flags_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_comparator_bist.sv
// tb_comparator_bist: directed table plus hand sequences against two BIST instances (halt-on-error and run-to-end)
module tb_comparator_bist;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int mode = 0;
    logic sel = 1'b0;
    logic start_s = 1'b0, start_n = 1'b0;
    logic [7:0] a_s, b_s, a_n, b_n, ea_s, eb_s, ea_n, eb_n;
    logic eq_s, lw_s, gr_s, eq_n, lw_n, gr_n;
    logic busy_s, done_s, pass_s, fail_s, busy_n, done_n, pass_n, fail_n;
    logic [2:0] ef_s, ef_n;
    logic [15:0] ec_s, ec_n;

    // Comparator model: 0 golden, 1 gr stuck at 0, 2 eq and lw both high on equality
    function automatic logic [2:0] cmp(input logic [7:0] a, input logic [7:0] b, input int m);
        return {a == b, (a < b) || (m == 2 && a == b), (a > b) && m != 1};
    endfunction

    assign {eq_s, lw_s, gr_s} = cmp(a_s, b_s, mode);
    assign {eq_n, lw_n, gr_n} = cmp(a_n, b_n, mode);

    comparator_bist #(.STOP_ON_ERR(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .a_o(a_s), .b_o(b_s),
        .eq_i(eq_s), .lw_i(lw_s), .gr_i(gr_s), .busy(busy_s), .done(done_s),
        .pass(pass_s), .fail(fail_s), .err_a(ea_s), .err_b(eb_s),
        .err_flags(ef_s), .err_count(ec_s)
    );

    comparator_bist #(.STOP_ON_ERR(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start_n), .a_o(a_n), .b_o(b_n),
        .eq_i(eq_n), .lw_i(lw_n), .gr_i(gr_n), .busy(busy_n), .done(done_n),
        .pass(pass_n), .fail(fail_n), .err_a(ea_n), .err_b(eb_n),
        .err_flags(ef_n), .err_count(ec_n)
    );

    logic done_x, busy_x, pass_x, fail_x;
    logic [7:0] a_x, b_x, ea_x, eb_x;
    logic [2:0] ef_x;
    logic [15:0] ec_x;

    always_comb begin
        done_x = sel ? done_n : done_s;
        busy_x = sel ? busy_n : busy_s;
        pass_x = sel ? pass_n : pass_s;
        fail_x = sel ? fail_n : fail_s;
        a_x    = sel ? a_n : a_s;
        b_x    = sel ? b_n : b_s;
        ea_x   = sel ? ea_n : ea_s;
        eb_x   = sel ? eb_n : eb_s;
        ef_x   = sel ? ef_n : ef_s;
        ec_x   = sel ? ec_n : ec_s;
    end

    int checks = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input logic s, input logic v);
        if (s) start_n = v;
        else start_s = v;
    endtask

    logic acc_busy, acc_fail;
    logic [15:0] acc_ec;
    logic [7:0] acc_a, acc_b;
    int visited, order_bad;

    // Call at #1 after a posedge; returns at #1 after the edge where done rose (n = edges from accept)
    task automatic run(input logic s, input int rp, output int n);
        logic [15:0] prev, cur, nxt;
        sel = s;
        set_start(s, 1'b1);
        @(posedge clk);
        #1;
        set_start(s, 1'b0);
        acc_busy = busy_x;
        acc_fail = fail_x;
        acc_ec = ec_x;
        acc_a = a_x;
        acc_b = b_x;
        prev = {a_x, b_x};
        visited = 1;
        order_bad = 0;
        n = 0;
        while (!done_x && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            set_start(s, n == rp);
            cur = {a_x, b_x};
            if (cur != prev) begin
                nxt = (prev[7:0] == 8'd15) ? {prev[15:8] + 8'd1, 8'd0} : {prev[15:8], prev[7:0] + 8'd1};
                if (cur != nxt) order_bad++;
                prev = cur;
                visited++;
            end
        end
        set_start(s, 1'b0);
    endtask

    typedef struct {
        int         mode;
        logic       sel;
        int         cyc;
        logic       pass;
        logic       fail;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [2:0] ef;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[5];
    int n;

    initial begin
        tbl[0] = '{0, 1'b0, 1025, 1'b1, 1'b0, 8'd0, 8'd0, 3'b000, 16'd0};
        tbl[1] = '{1, 1'b0, 69,   1'b0, 1'b1, 8'd1, 8'd0, 3'b000, 16'd1};
        tbl[2] = '{1, 1'b1, 1025, 1'b0, 1'b1, 8'd1, 8'd0, 3'b000, 16'd120};
        tbl[3] = '{2, 1'b0, 5,    1'b0, 1'b1, 8'd0, 8'd0, 3'b110, 16'd1};
        tbl[4] = '{2, 1'b1, 1025, 1'b0, 1'b1, 8'd0, 8'd0, 3'b110, 16'd16};

        #1;
        chk("rst_busy", {busy_s, busy_n}, 2'b00);
        chk("rst_done", {done_s, done_n}, 2'b00);
        chk("rst_pf", {pass_s, fail_s, pass_n, fail_n}, 4'b0000);
        chk("rst_ab", {a_s, b_s, a_n, b_n}, 32'd0);
        chk("rst_err", {ea_s, eb_s, ef_s, ec_s}, 35'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            run(tbl[i].sel, 0, n);
            chk($sformatf("v%0d_accept_busy", i), acc_busy, 1'b1);
            chk($sformatf("v%0d_cycles", i), n, tbl[i].cyc);
            chk($sformatf("v%0d_busy", i), busy_x, 1'b0);
            chk($sformatf("v%0d_pass", i), pass_x, tbl[i].pass);
            chk($sformatf("v%0d_fail", i), fail_x, tbl[i].fail);
            chk($sformatf("v%0d_err_a", i), ea_x, tbl[i].ea);
            chk($sformatf("v%0d_err_b", i), eb_x, tbl[i].eb);
            chk($sformatf("v%0d_err_flags", i), ef_x, tbl[i].ef);
            chk($sformatf("v%0d_err_count", i), ec_x, tbl[i].ec);
            if (tbl[i].cyc == 1025) begin
                chk($sformatf("v%0d_pairs", i), visited, 256);
                chk($sformatf("v%0d_order", i), order_bad, 0);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_width", i), done_x, 1'b0);
        end

        // Reset mid-sweep at a=5, b=9
        mode = 0;
        sel = 1'b0;
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        n = 0;
        while (!(a_s == 8'd5 && b_s == 8'd9) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_reached", {a_s, b_s}, {8'd5, 8'd9});
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ab", {a_s, b_s}, 16'd0);
        chk("mid_rst_flags", {busy_s, done_s, pass_s, fail_s}, 4'b0000);
        chk("mid_rst_err", {ea_s, eb_s, ef_s, ec_s}, 35'd0);
        chk("mid_rst_other", {pass_n, fail_n, ec_n}, 18'd0);
        n = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done_s) n++;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        if (done_s) n++;
        chk("mid_no_done", n, 0);
        run(1'b0, 0, n);
        chk("post_rst_cycles", n, 1025);
        chk("post_rst_pass", {pass_s, fail_s, ec_s}, {1'b1, 1'b0, 16'd0});
        @(posedge clk);
        #1;

        // start while busy and in the done cycle are ignored; a later start is honoured
        mode = 1;
        run(1'b1, 100, n);
        chk("rebusy_cycles", n, 1025);
        chk("rebusy_count", ec_n, 16'd120);
        start_n = 1'b1;
        @(posedge clk);
        #1;
        start_n = 1'b0;
        chk("done_cycle_start_busy", busy_n, 1'b0);
        chk("done_cycle_start_done", done_n, 1'b0);
        chk("done_cycle_start_keep", {fail_n, ec_n}, {1'b1, 16'd120});
        @(posedge clk);
        #1;
        mode = 0;
        run(1'b1, 0, n);
        chk("restart_busy", acc_busy, 1'b1);
        chk("restart_clear", {acc_fail, acc_ec}, 17'd0);
        chk("restart_ab", {acc_a, acc_b}, 16'd0);
        chk("restart_cycles", n, 1025);
        chk("restart_pass", {pass_n, fail_n, ec_n}, {1'b1, 1'b0, 16'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule

// File: doc/comparator_bist.md
Name: comparator_bist

Overview:
- Built-in self-test sequencer that drives and checks an N-bit magnitude comparator with equal/lower/greater outputs.
- Sweeps operand pairs (a, b) over SWEEP x SWEEP values: a outer loop, b inner loop.
- For each pair, waits a settle interval, samples the three result flags, and checks them against the expected strict one-hot result.
- Sits beside the comparator in silicon and replaces the simulation-only sweep with a synthesizable go/no-go engine.

Parameters:
- WIDTH, 8, operand width of a_o/b_o.
- SWEEP, 16, values per operand, 2..2**WIDTH; the sweep covers 0..SWEEP-1 for both a and b.
- SETTLE, 2, cycles operands are held before sampling flags, >=1.
- STOP_ON_ERR, 1, 1: halt on first mismatch; 0: log first mismatch and continue to end.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; accepted only in IDLE.
- a_o  out  WIDTH  operand a to comparator.
- b_o  out  WIDTH  operand b to comparator.
- eq_i  in  1  comparator equal flag.
- lw_i  in  1  comparator lower flag (a<b).
- gr_i  in  1  comparator greater flag (a>b).
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at sweep end or halt.
- pass  out  1  sticky; valid after done.
- fail  out  1  sticky; valid after done.
- err_a  out  WIDTH  a of first mismatch.
- err_b  out  WIDTH  b of first mismatch.
- err_flags  out  3  {eq,lw,gr} sampled at first mismatch.
- err_count  out  16  total mismatches; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE; a_o=b_o=0; busy=done=pass=fail=0; err_a=err_b=0; err_flags=0; err_count=0. A reset mid-sweep aborts the sweep; no done pulse is issued.
- States: IDLE, SETUP, SETTLE, CHECK, FINISH.
- IDLE: on start=1 -> SETUP.
  - Clear pass, fail, err_* and err_count.
  - Set a_o=0, b_o=0, busy=1.
- SETUP: load the settle counter with SETTLE-1 -> SETTLE.
- SETTLE: decrement the counter each cycle; when it reaches 0 -> CHECK. a_o/b_o are held stable throughout.
- CHECK: sample the flags once and form the expected value {a==b, a<b, a>b} (unsigned).
  - Mismatch = any of the three bits differs. The check is strict: exactly one flag is high, and it is the correct one.
  - On mismatch:
    - Increment err_count (saturating).
    - If fail==0, capture err_a, err_b and err_flags, then set fail=1.
  - If mismatch and STOP_ON_ERR=1 -> FINISH.
  - Else if b_o==SWEEP-1 and a_o==SWEEP-1 -> FINISH.
  - Else if b_o==SWEEP-1: b_o=0, a_o=a_o+1 -> SETUP.
  - Else: b_o=b_o+1 -> SETUP.
- FINISH: done=1 for exactly one cycle; busy=0; pass = !fail -> IDLE.
- Per-pair cost: 1 SETUP cycle + SETTLE cycles + 1 CHECK cycle. A full clean sweep takes SWEEP*SWEEP*(SETTLE+2)+1 cycles from the start-accept edge to the done pulse.
- Operand counters are WIDTH bits. Wrap-around never occurs because the end test precedes the increment; SWEEP=2**WIDTH is legal.
- start while busy: ignored.
- start in the same cycle as done: ignored; a new start is needed in IDLE.
- pass, fail and err_* hold their values in IDLE until the next accepted start.
- eq_i/lw_i/gr_i are sampled only in CHECK. Values outside CHECK are don't-care; X outside CHECK must not corrupt state.

Test Plan:
- Golden comparator attached, defaults, start pulse -> done after 16*16*4+1=1025 cycles; pass=1, fail=0, err_count=0; a_o/b_o visit all 256 pairs in order.
- gr_i stuck-at-0, STOP_ON_ERR=1 -> halt at first a>b pair (a=1,b=0): fail=1, err_a=1, err_b=0, err_flags=3'b000, err_count=1.
- Same fault, STOP_ON_ERR=0 -> full sweep; err_count=120 (pairs with a>b); err_a=1, err_b=0; pass=0.
- eq_i and lw_i both forced high when a==b (non-one-hot) -> fail; first error a=0, b=0, err_flags=3'b110.
- rst_n asserted low mid-sweep (a=5, b=9) -> all outputs 0 immediately; no done pulse; a fresh start then runs a clean 1025-cycle sweep.
- start re-pulsed while busy, and again in the done cycle -> neither restarts the sweep; a start 2 cycles after done begins a new sweep, clears err_count, and sets busy.
